mpadd_seq: RTL and testbench

Multi-precision adder/subtractor sequencer. It reuses one 16-bit ripple-carry adder slice iteratively to add or subtract WORDS-word operands, processing one 16-bit word per clock cycle from LSW to MSW. A registered carry chains between words. The block sits between a requesting controller (start/done handshake) and the shared 16-bit adder datapath.

---
 rtl/mpadd_seq_if.sv | 26 ++
 rtl/mpadd_seq.sv | 87 ++++++++
 tb/tb_mpadd_seq.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/mpadd_seq_if.sv
// Request/result bundle between a controller and the multi-precision add sequencer.
// The controller drives operands and start; the sequencer returns status and result.
interface mpadd_seq_if #(
   parameter int W     = 16,
   parameter int WORDS = 4
);
   logic                 start;
   logic                 sub;
   logic                 cin;
   logic [W*WORDS-1:0]   a;
   logic [W*WORDS-1:0]   b;
   logic                 busy;
   logic                 done;
   logic [W*WORDS-1:0]   sum;
   logic                 cout;

   modport master (
      output start, sub, cin, a, b,
      input  busy, done, sum, cout
   );

   modport slave (
      input  start, sub, cin, a, b,
      output busy, done, sum, cout
   );
endinterface

// File: rtl/mpadd_seq.sv
// Multi-precision add/subtract sequencer: one W-bit slice reused LSW to MSW,
// with the inter-word carry chained through a register.
module mpadd_seq #(
   parameter int W     = 16,
   parameter int WORDS = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   mpadd_seq_if.slave  bus
);
   localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                     state, state_nxt;
   logic [WORDS-1:0][W-1:0]    a_q, b_q, sum_q;
   logic                       carry_q;
   logic                       cout_q;
   logic [IW-1:0]              idx_q;
   logic                       last_w;
   logic [W-1:0]               s_w;
   logic                       c_w;

   // Subtraction arrives here already as a + ~b + 1, so the slice only ever adds.
   assign {c_w, s_w} = {1'b0, a_q[idx_q]} + {1'b0, b_q[idx_q]} + {{W{1'b0}}, carry_q};
   assign last_w     = (idx_q == IW'(WORDS - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = RUN;
         RUN:     if (last_w)    state_nxt = DONE;
         DONE:                   state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.busy = (state == RUN);
      bus.done = (state == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         idx_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  a_q     <= bus.a;
                  b_q     <= bus.sub ? ~bus.b : bus.b;
                  carry_q <= bus.sub ? 1'b1 : bus.cin;
                  idx_q   <= '0;
                  sum_q   <= '0;
               end
            end
            RUN: begin
               sum_q[idx_q] <= s_w;
               carry_q      <= c_w;
               // Index saturates on the last word so it never leaves 0..WORDS-1.
               if (last_w) begin
                  cout_q <= c_w;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;
endmodule

// File: tb/tb_mpadd_seq.sv
// Bench for mpadd_seq: directed and random operations against a whole-operand
// arithmetic reference, plus handshake, back-to-back and async-reset scenarios.
module tb_mpadd_seq;
   localparam int W     = 16;
   localparam int WORDS = 4;
   localparam int N     = W * WORDS;
   localparam int NP    = N + 1;

   logic clk;
   logic rst_n;
   int   tests;
   int   fails;
   int   done_cnt;

   mpadd_seq_if #(.W(W), .WORDS(WORDS)) bus ();

   mpadd_seq #(.W(W), .WORDS(WORDS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (bus.done) done_cnt++;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // Whole-operand reference: result is {cout, sum}.
   function automatic logic [N:0] model(input logic [N-1:0] ma, input logic [N-1:0] mb,
                                         input logic msub, input logic mcin);
      logic [N:0] r;
      if (msub) begin
         r[N-1:0] = ma - mb;
         r[N]     = (ma >= mb);
      end else begin
         r = {1'b0, ma} + {1'b0, mb} + {{N{1'b0}}, mcin};
      end
      return r;
   endfunction

   task automatic chk(input string tag, input logic [N:0] obs, input logic [N:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called #1 after an edge with the DUT idle; returns #1 after the edge ending done.
   task automatic do_op(input string tag, input logic [N-1:0] ta, input logic [N-1:0] tb_,
                        input logic ts, input logic tc);
      logic [N:0] exp;
      int n;
      int d0;
      exp = model(ta, tb_, ts, tc);
      bus.a = ta; bus.b = tb_; bus.sub = ts; bus.cin = tc; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      d0 = done_cnt;
      n = 0;
      while (bus.busy && n < WORDS + 8) begin
         n++;
         @(posedge clk); #1;
      end
      chk({tag, ".busy_cycles"}, NP'(n), NP'(WORDS));
      chk({tag, ".done"}, NP'(bus.done), NP'(1));
      chk({tag, ".sum"}, NP'(bus.sum), NP'(exp[N-1:0]));
      chk({tag, ".cout"}, NP'(bus.cout), NP'(exp[N]));
      @(posedge clk); #1;
      chk({tag, ".done_low"}, NP'(bus.done), NP'(0));
      chk({tag, ".one_done"}, NP'(done_cnt - d0), NP'(1));
   endtask

   initial begin
      logic [N-1:0] ra, rb;
      logic [N:0]   exp;
      logic         rs, rc;
      int           n, d0;
      int           rises[$];
      logic         prev_busy;

      tests = 0; fails = 0; done_cnt = 0;
      bus.start = 1'b0; bus.sub = 1'b0; bus.cin = 1'b0; bus.a = '0; bus.b = '0;

      // Reset, then idle
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst.busy", NP'(bus.busy), NP'(0));
      chk("rst.sum", NP'(bus.sum), NP'(0));
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("idle.busy", NP'(bus.busy), NP'(0));
      chk("idle.done", NP'(bus.done), NP'(0));
      chk("idle.sum", NP'(bus.sum), NP'(0));
      chk("idle.cout", NP'(bus.cout), NP'(0));
      chk("idle.no_done", NP'(done_cnt), NP'(0));

      // Directed arithmetic
      do_op("add23_6", N'(23), N'(6), 1'b0, 1'b0);
      do_op("ripple", {N{1'b1}}, N'(1), 1'b0, 1'b0);
      do_op("ones_cin", {N{1'b1}}, {N{1'b1}}, 1'b0, 1'b1);
      do_op("sub_borrow_chain", N'(64'h0000_0000_0001_0000), N'(1), 1'b1, 1'b0);
      do_op("sub_neg", N'(5), N'(6), 1'b1, 1'b0);
      do_op("sub_zero", N'(64'h1234_5678_9abc_def0), N'(0), 1'b1, 1'b1);

      // Randomized operations
      for (int i = 0; i < 10; i++) begin
         ra = {$urandom, $urandom};
         rb = (i % 3 == 0) ? ~ra : {$urandom, $urandom};
         rs = 1'($urandom_range(0, 1));
         rc = 1'($urandom_range(0, 1));
         do_op($sformatf("rand%0d", i), ra, rb, rs, rc);
      end

      // Start during busy plus operand changes mid-run are ignored
      exp = model(N'(23), N'(6), 1'b0, 1'b0);
      bus.a = N'(23); bus.b = N'(6); bus.sub = 1'b0; bus.cin = 1'b0; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      d0 = done_cnt;
      @(posedge clk); #1;
      bus.start = 1'b1; bus.a = {$urandom, $urandom}; bus.b = {$urandom, $urandom};
      bus.sub = 1'b1; bus.cin = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      n = 0;
      while (bus.busy && n < WORDS + 8) begin
         n++;
         @(posedge clk); #1;
      end
      chk("proto.done", NP'(bus.done), NP'(1));
      chk("proto.sum", NP'(bus.sum), NP'(exp[N-1:0]));
      chk("proto.cout", NP'(bus.cout), NP'(exp[N]));
      repeat (WORDS + 3) @(posedge clk);
      #1;
      chk("proto.one_done", NP'(done_cnt - d0), NP'(1));
      chk("proto.idle", NP'(bus.busy), NP'(0));

      // Back-to-back with start held high
      ra = {$urandom, $urandom}; rb = {$urandom, $urandom};
      exp = model(ra, rb, 1'b0, 1'b1);
      bus.a = ra; bus.b = rb; bus.sub = 1'b0; bus.cin = 1'b1; bus.start = 1'b1;
      prev_busy = 1'b0;
      for (int i = 0; i < 3 * (WORDS + 2) + 1; i++) begin
         @(posedge clk); #1;
         if (bus.busy && !prev_busy) rises.push_back(i);
         prev_busy = bus.busy;
         if (bus.done) begin
            chk("b2b.sum", NP'(bus.sum), NP'(exp[N-1:0]));
            chk("b2b.busy_with_done", NP'(bus.busy), NP'(0));
         end
      end
      bus.start = 1'b0;
      chk("b2b.accepts", NP'(rises.size()), NP'(4));
      if (rises.size() >= 3) begin
         chk("b2b.period1", NP'(rises[1] - rises[0]), NP'(WORDS + 2));
         chk("b2b.period2", NP'(rises[2] - rises[1]), NP'(WORDS + 2));
      end
      repeat (WORDS + 3) @(posedge clk);
      #1;

      // Asynchronous reset during word 2
      do_op("pre_rst", {N{1'b1}}, N'(1), 1'b0, 1'b0);
      bus.a = N'(64'h1111_2222_3333_4444); bus.b = N'(64'h0101_0202_0303_0404);
      bus.sub = 1'b0; bus.cin = 1'b0; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      d0 = done_cnt;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("midrun.busy", NP'(bus.busy), NP'(1));
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst.busy", NP'(bus.busy), NP'(0));
      chk("arst.done", NP'(bus.done), NP'(0));
      chk("arst.sum", NP'(bus.sum), NP'(0));
      chk("arst.cout", NP'(bus.cout), NP'(0));
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      repeat (WORDS + 2) @(posedge clk);
      #1;
      chk("arst.no_done", NP'(done_cnt - d0), NP'(0));
      chk("arst.idle", NP'(bus.busy), NP'(0));
      do_op("post_rst", N'(6), N'(6), 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
